// File: rtl/mem_ctrl.sv
// mem_ctrl: cache-line read/write controller for a shared A2/D2/C2 memory bus,
// with a response timeout.
module mem_ctrl #(
   parameter int LINE_WORDS = 8,
   parameter int TIMEOUT    = 200
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [13:0]                line_addr_i,
   input  logic [LINE_WORDS*16-1:0]   wdata_i,
   output logic [LINE_WORDS*16-1:0]   rdata_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic                       busy_o,
   output logic [13:0]                a2_o,
   output logic                       a2_oe_o,
   output logic [15:0]                d2_o,
   output logic                       d2_oe_o,
   input  logic [15:0]                d2_i,
   output logic [1:0]                 c2_o,
   output logic                       c2_oe_o,
   input  logic [1:0]                 c2_i
);
   localparam int BW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] C_NOP = 2'd0, C_RESP = 2'd1, C_RD = 2'd2, C_WR = 2'd3;
   localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, FIN} state_t;

   state_t                   state_q, state_d;
   logic [BW-1:0]            beat_q, beat_d;
   logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
   logic [13:0]              addr_q, addr_d;
   logic [LINE_WORDS*16-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic                     err_q, err_d;
   logic                     resp;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         beat_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign resp    = c2_i == C_RESP;
   assign cnt_inc = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;

   // A response on the cycle the counter would expire wins over the timeout.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (req_i) begin
            addr_d  = line_addr_i;
            wdata_d = wdata_i;
            beat_d  = '0;
            state_d = we_i ? WR_DATA : RD_CMD;
         end
         RD_CMD: begin
            cnt_d   = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT, WR_WAIT: begin
            cnt_d = cnt_inc;
            if (resp) begin
               if (state_q == RD_WAIT) rdata_d[15:0] = d2_i;
               beat_d  = BW'(1);
               state_d = state_q == RD_WAIT ? (LINE_WORDS > 1 ? RD_DATA : FIN) : FIN;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         RD_DATA: begin
            rdata_d[16*beat_q +: 16] = d2_i;
            beat_d  = beat_q + 1'b1;
            state_d = beat_q == LAST ? FIN : RD_DATA;
         end
         WR_DATA: begin
            beat_d  = beat_q + 1'b1;
            cnt_d   = '0;
            state_d = beat_q == LAST ? WR_WAIT : WR_DATA;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus drives decode from the state register only, so they never follow c2_i/d2_i.
   always_comb begin
      a2_oe_o = state_q == RD_CMD || (state_q == WR_DATA && beat_q == '0);
      c2_oe_o = state_q == RD_CMD || state_q == WR_DATA;
      d2_oe_o = state_q == WR_DATA;
      c2_o    = state_q == RD_CMD ? C_RD : (state_q == WR_DATA && beat_q == '0) ? C_WR : C_NOP;
      a2_o    = addr_q;
      d2_o    = wdata_q[16*beat_q +: 16];
      done_o  = state_q == FIN;
      busy_o  = state_q != IDLE;
      err_o   = err_q;
      rdata_o = rdata_q;
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with queued expectations; a negedge monitor
// checks every bus command, write beat and completion against the queues.
module tb_mem_ctrl;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0, we = 1'b0;
   logic [13:0]  addr = '0;
   logic [127:0] wdata = '0;
   logic [127:0] rdata;
   logic         done, err, busy;
   logic [13:0]  a2_o;
   logic         a2_oe, d2_oe, c2_oe;
   logic [15:0]  d2_o, mem_d2 = '0, d2_i;
   logic [1:0]   c2_o, mem_c2 = '0, c2_i;

   int n_tests = 0, n_fail = 0;
   logic [127:0] last_rdata = '0;
   logic [16:0]  cmd_q[$];
   logic [18:0]  wbeat_q[$];
   logic [128:0] resp_q[$];

   assign c2_i = c2_oe ? c2_o : mem_c2;
   assign d2_i = d2_oe ? d2_o : mem_d2;

   mem_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .line_addr_i(addr),
      .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .err_o(err), .busy_o(busy),
      .a2_o(a2_o), .a2_oe_o(a2_oe), .d2_o(d2_o), .d2_oe_o(d2_oe), .d2_i(d2_i),
      .c2_o(c2_o), .c2_oe_o(c2_oe), .c2_i(c2_i)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: output asserted with nothing expected", name);
   endtask

   always @(negedge clk) if (rst_n) begin
      if (a2_oe) begin
         if (cmd_q.size() == 0) unexpected("cmd");
         else check("cmd", {c2_oe, c2_o, a2_o}, cmd_q.pop_front());
      end
      if (d2_oe) begin
         if (wbeat_q.size() == 0) unexpected("wbeat");
         else check("wbeat", {c2_oe, c2_o, d2_o}, wbeat_q.pop_front());
      end
      if (done || err) begin
         if (resp_q.size() == 0) unexpected("resp");
         else check("resp", {err, rdata}, resp_q.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] ramp(input logic [15:0] base);
      logic [127:0] e;
      for (int k = 0; k < 8; k++) e[16*k +: 16] = base + 16'(k);
      return e;
   endfunction

   task automatic beats(input logic [15:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         mem_c2 = k == 0 ? 2'd1 : 2'd0;
         mem_d2 = base + 16'(k);
         tick(1);
      end
      mem_c2 = 2'd0;
   endtask

   task automatic do_read(input logic [13:0] a, input int dly, input logic [15:0] base);
      cmd_q.push_back({1'b1, 2'd2, a});
      last_rdata = ramp(base);
      resp_q.push_back({1'b0, last_rdata});
      req = 1'b1; we = 1'b0; addr = a;
      tick(1);
      req = 1'b0;
      tick(1 + dly);
      beats(base, 8);
      check("rd_done", {err, done}, 2'b01);
      tick(1);
   endtask

   task automatic do_write(input logic [13:0] a, input logic [127:0] d, input int dly);
      cmd_q.push_back({1'b1, 2'd3, a});
      for (int k = 0; k < 8; k++) wbeat_q.push_back({1'b1, k == 0 ? 2'd3 : 2'd0, d[16*k +: 16]});
      resp_q.push_back({1'b0, last_rdata});
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick(1);
      req = 1'b0;
      tick(8 + dly);
      mem_c2 = 2'd1;
      tick(1);
      mem_c2 = 2'd0;
      check("wr_done", {err, done}, 2'b01);
      tick(1);
   endtask

   initial begin
      #1;
      check("reset_outputs", {a2_oe, d2_oe, c2_oe, done, err, busy}, '0);
      check("reset_rdata", rdata, '0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      check("idle_busy", busy, 1'b0);

      do_read(14'h0123, 100, 16'h0000);
      check("rd_rdata", rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      do_write(14'h0456, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 10);
      do_read(14'h3FFF, 0, 16'hA5A0);
      do_write(14'h0001, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);

      // read timeout: err exactly 200 cycles after RD_WAIT entry, never done
      cmd_q.push_back({1'b1, 2'd2, 14'h0777});
      resp_q.push_back({1'b1, last_rdata});
      req = 1'b1; we = 1'b0; addr = 14'h0777;
      tick(1);
      req = 1'b0;
      tick(1);
      tick(199);
      check("to_early", {err, busy}, 2'b01);
      tick(1);
      check("to_err", {err, busy, done}, 3'b100);
      tick(1);
      check("to_after", {err, busy}, 2'b00);

      // responses on the last counting cycle win over the timeout
      do_write(14'h0200, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 199);
      do_read(14'h0201, 199, 16'h5000);

      // reset during RD_DATA beat 3
      cmd_q.push_back({1'b1, 2'd2, 14'h0300});
      req = 1'b1; we = 1'b0; addr = 14'h0300;
      tick(1);
      req = 1'b0;
      tick(3);
      beats(16'h7700, 3);
      check("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_outputs", {a2_oe, d2_oe, c2_oe, done, err, busy}, '0);
      check("rst_rdata", rdata, '0);
      last_rdata = '0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("rst_idle", busy, 1'b0);
      do_read(14'h0301, 4, 16'h0900);

      // back-to-back: req held high through done, then stray req during busy
      cmd_q.push_back({1'b1, 2'd2, 14'h0400});
      cmd_q.push_back({1'b1, 2'd2, 14'h0400});
      resp_q.push_back({1'b0, ramp(16'h0100)});
      resp_q.push_back({1'b0, ramp(16'h0200)});
      req = 1'b1; we = 1'b0; addr = 14'h0400;
      tick(2 + 5);
      beats(16'h0100, 8);
      check("b2b_done1", done, 1'b1);
      tick(1);
      check("b2b_idle", busy, 1'b0);
      tick(1);
      check("b2b_start2", {busy, c2_oe, c2_o}, 4'b1110);
      req = 1'b0;
      tick(2);
      req = 1'b1; we = 1'b1;
      tick(1);
      req = 1'b0;
      tick(1);
      beats(16'h0200, 8);
      check("b2b_done2", done, 1'b1);
      last_rdata = ramp(16'h0200);
      tick(6);
      check("b2b_quiet", busy, 1'b0);

      check("cmd_q_empty", 129'(cmd_q.size()), 129'd0);
      check("wbeat_q_empty", 129'(wbeat_q.size()), 129'd0);
      check("resp_q_empty", 129'(resp_q.size()), 129'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
